// File: rtl/i2s_ctrl_pkg.sv
// Shared definitions for the I2S transmit controller: FSM state encoding and
// the default maximum sample width.
package i2s_ctrl_pkg;

    localparam int MAX_RES_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } tx_state_t;

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles sck every (ratio+1) clocks while run is high and flags
// the cycle on which the next rising or falling edge will be registered.
module i2s_sck_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [4:0] ratio,
    output logic       sck,
    output logic       rise_stb,
    output logic       fall_stb
);

    logic [4:0] cnt;
    logic       wrap;

    assign wrap     = run && (cnt == ratio);
    assign rise_stb = wrap && !sck;
    assign fall_stb = wrap && sck;

    // Stopping the divider parks sck low so every channel starts with a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmitter: one-entry sample holding register, frame FSM and serialiser.
// Optional underflow counter port is enabled by I2S_TX_CTRL_UNDERFLOW_CNT_EN.
module i2s_tx_ctrl
    import i2s_ctrl_pkg::*;
#(
    parameter int MAX_RES = MAX_RES_DEFAULT
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               ctrl_en,
    input  logic               ctrl_int_en,
    input  logic               ctrl_ch_swap,
    input  logic               ctrl_mlsbf,
    input  logic [5:0]         ctrl_samp_res,
    input  logic [4:0]         ctrl_freq_ratio,
    input  logic [MAX_RES-1:0] s_left,
    input  logic [MAX_RES-1:0] s_right,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               irq_clr,
    output logic               i2s_sck,
    output logic               i2s_ws,
    output logic               i2s_sd,
    output logic               irq,
    output logic               busy
`ifdef I2S_TX_CTRL_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]        underflow_cnt
`endif
);

    tx_state_t          state, state_nxt;
    logic               hold_full, rdy_en;
    logic [MAX_RES-1:0] hold_l, hold_r;
    logic [MAX_RES-1:0] sh_l, sh_r, sh_cur, sh_nxt;
    logic [MAX_RES-1:0] first_al, second_al;
    logic               lsbf_q, ws_q, sd_q, irq_q;
    logic [5:0]         res_q, res_in, bit_cnt;
    logic [4:0]         ratio_q;
    logic               load, accept, underflow, chan_end;
    logic               sck_run, sck_rise, sck_fall;

    function automatic logic [5:0] eff_res(input logic [5:0] r);
        if (r >= 6'd1 && r <= 6'(MAX_RES)) return r;
        return 6'(MAX_RES);
    endfunction

    // MSB-first data is left-aligned so the serialiser always reads the top bit.
    function automatic logic [MAX_RES-1:0] align(input logic [MAX_RES-1:0] d,
                                                 input logic [5:0] r, input logic lsbf);
        return lsbf ? d : (d << (6'(MAX_RES) - r));
    endfunction

    function automatic logic head(input logic [MAX_RES-1:0] sh, input logic lsbf);
        return lsbf ? sh[0] : sh[MAX_RES-1];
    endfunction

    function automatic logic [MAX_RES-1:0] advance(input logic [MAX_RES-1:0] sh, input logic lsbf);
        return lsbf ? (sh >> 1) : (sh << 1);
    endfunction

    assign load      = (state == ST_LOAD);
    assign s_ready   = rdy_en && (!hold_full || load);
    assign accept    = s_valid && s_ready;
    assign underflow = load && !hold_full;
    assign res_in    = eff_res(ctrl_samp_res);
    assign first_al  = hold_full ? align(ctrl_ch_swap ? hold_r : hold_l, res_in, ctrl_mlsbf) : '0;
    assign second_al = hold_full ? align(ctrl_ch_swap ? hold_l : hold_r, res_in, ctrl_mlsbf) : '0;
    assign sck_run   = (state == ST_LEFT) || (state == ST_RIGHT);
    assign chan_end  = (bit_cnt == res_q);
    assign sh_cur    = (state == ST_LEFT) ? sh_l : sh_r;
    assign sh_nxt    = advance(sh_cur, lsbf_q);

    assign i2s_ws = ws_q;
    assign i2s_sd = sd_q;
    assign irq    = irq_q;
    assign busy   = (state != ST_IDLE);

    i2s_sck_gen u_sck_gen (
        .clk      (axi_aclk),
        .rst_n    (axi_aresetn),
        .run      (sck_run),
        .ratio    (ratio_q),
        .sck      (i2s_sck),
        .rise_stb (sck_rise),
        .fall_stb (sck_fall)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ctrl_en) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_LEFT;
            ST_LEFT:  if (sck_fall && chan_end) state_nxt = ST_RIGHT;
            ST_RIGHT: if (sck_fall && chan_end) state_nxt = ctrl_en ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // bit_cnt counts bits already sampled by the receiver (rising edges) in this channel.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rdy_en    <= 1'b0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
            lsbf_q    <= 1'b0;
            res_q     <= 6'(MAX_RES);
            ratio_q   <= '0;
            bit_cnt   <= '0;
            ws_q      <= 1'b0;
            sd_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                hold_full <= 1'b1;
                hold_l    <= s_left;
                hold_r    <= s_right;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (underflow && ctrl_int_en) irq_q <= 1'b1;
            else if (irq_clr)             irq_q <= 1'b0;
            if (sck_rise) bit_cnt <= bit_cnt + 6'd1;
            case (state)
                ST_LOAD: begin
                    lsbf_q  <= ctrl_mlsbf;
                    res_q   <= res_in;
                    ratio_q <= ctrl_freq_ratio;
                    sh_l    <= first_al;
                    sh_r    <= second_al;
                    sd_q    <= head(first_al, ctrl_mlsbf);
                    ws_q    <= (res_in == 6'd1);
                    bit_cnt <= '0;
                end
                ST_LEFT, ST_RIGHT: begin
                    if (sck_fall) begin
                        if (chan_end) begin
                            bit_cnt <= '0;
                            if (state == ST_LEFT) begin
                                sd_q <= head(sh_r, lsbf_q);
                                ws_q <= (res_q != 6'd1);
                            end else begin
                                sd_q <= 1'b0;
                                ws_q <= 1'b0;
                            end
                        end else begin
                            if (state == ST_LEFT) sh_l <= sh_nxt;
                            else                  sh_r <= sh_nxt;
                            sd_q <= head(sh_nxt, lsbf_q);
                            // ws flips together with the last bit of the channel.
                            if (bit_cnt == res_q - 6'd1) ws_q <= (state == ST_LEFT);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef I2S_TX_CTRL_UNDERFLOW_CNT_EN
    logic [15:0] uflow_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)   uflow_cnt <= '0;
        else if (underflow) uflow_cnt <= sat_inc16(uflow_cnt);
        else if (irq_clr)   uflow_cnt <= '0;
    end

    assign underflow_cnt = uflow_cnt;
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: captures (ws, sd) at every SCK rising
// edge and compares against a frame-level model of the I2S bit stream.
`timescale 1ns/1ps
module tb_i2s_tx_ctrl;

    localparam int MAX_RES = 32;

    logic               axi_aclk = 1'b0;
    logic               axi_aresetn = 1'b1;
    logic               ctrl_en = 1'b0, ctrl_int_en = 1'b0, ctrl_ch_swap = 1'b0, ctrl_mlsbf = 1'b0;
    logic [5:0]         ctrl_samp_res = 6'd16;
    logic [4:0]         ctrl_freq_ratio = 5'd1;
    logic [MAX_RES-1:0] s_left = '0, s_right = '0;
    logic               s_valid = 1'b0, irq_clr = 1'b0;
    logic               s_ready, i2s_sck, i2s_ws, i2s_sd, irq, busy;

    int checks = 0;
    int errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    i2s_tx_ctrl #(.MAX_RES(MAX_RES)) dut (
        .axi_aclk        (axi_aclk),
        .axi_aresetn     (axi_aresetn),
        .ctrl_en         (ctrl_en),
        .ctrl_int_en     (ctrl_int_en),
        .ctrl_ch_swap    (ctrl_ch_swap),
        .ctrl_mlsbf      (ctrl_mlsbf),
        .ctrl_samp_res   (ctrl_samp_res),
        .ctrl_freq_ratio (ctrl_freq_ratio),
        .s_left          (s_left),
        .s_right         (s_right),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .irq_clr         (irq_clr),
        .i2s_sck         (i2s_sck),
        .i2s_ws          (i2s_ws),
        .i2s_sd          (i2s_sd),
        .irq             (irq),
        .busy            (busy)
    );

    // Receiver view: what a sink latches on each SCK rising edge.
    logic       sck_prev = 1'b0;
    int         cyc = 0;
    logic [1:0] cap_q[$];
    int         rise_t[$];
    logic [1:0] exp_q[$];

    always @(negedge axi_aclk) begin
        cyc      <= cyc + 1;
        sck_prev <= i2s_sck;
        if (i2s_sck && !sck_prev) begin
            cap_q.push_back({i2s_ws, i2s_sd});
            rise_t.push_back(cyc);
        end
    end

    function automatic int eff_res(input int r);
        return (r >= 1 && r <= MAX_RES) ? r : MAX_RES;
    endfunction

    // I2S framing: first channel has ws=0, second ws=1, and ws already shows the
    // next channel while the last bit of the current one is on the line.
    task automatic add_frame(input logic [MAX_RES-1:0] l, input logic [MAX_RES-1:0] r,
                             input logic swap, input logic lsbf, input int res_cfg);
        int res;
        logic [MAX_RES-1:0] a, b;
        logic w, d;
        res = eff_res(res_cfg);
        a = swap ? r : l;
        b = swap ? l : r;
        for (int i = 0; i < res; i++) begin
            w = (i == res - 1);
            d = lsbf ? a[i] : a[res-1-i];
            exp_q.push_back({w, d});
        end
        for (int i = 0; i < res; i++) begin
            w = (i != res - 1);
            d = lsbf ? b[i] : b[res-1-i];
            exp_q.push_back({w, d});
        end
    endtask

    function automatic int first_mismatch();
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) return i;
        if (cap_q.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    function automatic int bad_period(input int want);
        for (int k = 1; k < rise_t.size(); k++)
            if (rise_t[k] - rise_t[k-1] != want) return k;
        return -1;
    endfunction

    function automatic logic [1:0] cap_at(input int i);
        return (i >= 0 && i < cap_q.size()) ? cap_q[i] : 2'bxx;
    endfunction

    function automatic logic [1:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 2'bxx;
    endfunction

    task automatic push_pair(input logic [MAX_RES-1:0] l, input logic [MAX_RES-1:0] r, output bit ok);
        ok = 1'b0;
        @(negedge axi_aclk);
        s_left = l; s_right = r; s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (s_ready) begin
                @(posedge axi_aclk);
                ok = 1'b1;
                break;
            end
            @(negedge axi_aclk);
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit done);
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge axi_aclk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    // Runs one frame, scrambling all controls and dropping ctrl_en once LEFT starts.
    task automatic drive_frame(input bit have_pair, input logic [MAX_RES-1:0] l,
                               input logic [MAX_RES-1:0] r, input logic swap, input logic lsbf,
                               input logic [5:0] res, input logic [4:0] ratio,
                               input bit clr_in_load, output bit push_ok, output bit done);
        push_ok = 1'b1;
        if (have_pair) push_pair(l, r, push_ok);
        @(negedge axi_aclk);
        cap_q.delete(); rise_t.delete(); exp_q.delete();
        ctrl_ch_swap = swap; ctrl_mlsbf = lsbf; ctrl_samp_res = res; ctrl_freq_ratio = ratio;
        ctrl_en = 1'b1;
        @(negedge axi_aclk);
        irq_clr = clr_in_load;
        @(negedge axi_aclk);
        irq_clr = 1'b0;
        ctrl_en = 1'b0;
        ctrl_ch_swap = ~swap; ctrl_mlsbf = ~lsbf;
        ctrl_samp_res = 6'($urandom_range(1, 63));
        ctrl_freq_ratio = 5'($urandom_range(0, 31));
        wait_idle(done);
    endtask

    task automatic test_reset();
        #2 axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({s_ready, i2s_sck, i2s_ws, i2s_sd, irq, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {s_ready, i2s_sck, i2s_ws, i2s_sd, irq, busy});
        end
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", s_ready);
        end
        @(posedge axi_aclk); #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release got ready=%b busy=%b want ready=1 busy=0", s_ready, busy);
        end
    endtask

    task automatic test_patterns();
        logic [MAX_RES-1:0] l, r;
        logic swap, lsbf;
        logic [5:0] res;
        logic [4:0] ratio;
        bit ok, done;
        int mm, bp;
        for (int c = 0; c < 5; c++) begin
            l = $urandom; r = $urandom;
            case (c)
                0: begin l = 32'h0000A5F0; r = 32'h00000F0F; swap = 0; lsbf = 0; res = 16; ratio = 1; end
                1: begin l = 32'h0000A5F0; r = 32'h00000F0F; swap = 1; lsbf = 1; res = 16; ratio = 1; end
                2: begin swap = 0; lsbf = 0; res = 24; ratio = 2; end
                3: begin swap = 0; lsbf = 1; res = 0;  ratio = 0; end
                default: begin swap = 1; lsbf = 0; res = 40; ratio = 1; end
            endcase
            drive_frame(1'b1, l, r, swap, lsbf, res, ratio, 1'b0, ok, done);
            add_frame(l, r, swap, lsbf, int'(res));
            checks++;
            if (!ok || !done) begin
                errors++;
                $display("FAIL case%0d handshake_or_timeout got ok=%0b done=%0b want 1 1", c, ok, done);
            end
            checks++;
            if (cap_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL case%0d bit_count got %0d want %0d", c, cap_q.size(), exp_q.size());
            end
            mm = first_mismatch();
            checks++;
            if (mm != -1) begin
                errors++;
                $display("FAIL case%0d stream bit %0d ws,sd got %b want %b", c, mm, cap_at(mm), exp_at(mm));
            end
            bp = bad_period(2 * (int'(ratio) + 1));
            checks++;
            if (bp != -1) begin
                errors++;
                $display("FAIL case%0d sck_period at rise %0d got %0d want %0d", c, bp,
                         rise_t[bp] - rise_t[bp-1], 2 * (int'(ratio) + 1));
            end
            checks++;
            if ({i2s_sck, i2s_ws, i2s_sd, busy} !== 4'b0) begin
                errors++;
                $display("FAIL case%0d idle_outputs got %b want 0000", c, {i2s_sck, i2s_ws, i2s_sd, busy});
            end
        end
    endtask

    task automatic test_random();
        logic [MAX_RES-1:0] l, r;
        logic swap, lsbf;
        logic [5:0] res;
        logic [4:0] ratio;
        bit ok, done;
        int mm, bp;
        for (int n = 0; n < 6; n++) begin
            l = $urandom; r = $urandom;
            swap = 1'($urandom_range(0, 1));
            lsbf = 1'($urandom_range(0, 1));
            res = 6'($urandom_range(0, 63));
            ratio = 5'($urandom_range(0, 3));
            drive_frame(1'b1, l, r, swap, lsbf, res, ratio, 1'b0, ok, done);
            add_frame(l, r, swap, lsbf, int'(res));
            mm = first_mismatch();
            checks++;
            if (!done || mm != -1) begin
                errors++;
                $display("FAIL rand%0d stream res=%0d bit %0d got %b want %b done=%0b", n, res, mm,
                         cap_at(mm), exp_at(mm), done);
            end
            bp = bad_period(2 * (int'(ratio) + 1));
            checks++;
            if (bp != -1) begin
                errors++;
                $display("FAIL rand%0d sck_period at rise %0d got %0d want %0d", n, bp,
                         rise_t[bp] - rise_t[bp-1], 2 * (int'(ratio) + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [MAX_RES-1:0] l1, r1, l2, r2;
        logic lsbf;
        int res, mm;
        bit ok, done, got2, reached;
        l1 = $urandom; r1 = $urandom; l2 = $urandom; r2 = $urandom;
        res = $urandom_range(8, 20);
        lsbf = 1'($urandom_range(0, 1));
        push_pair(l1, r1, ok);
        @(negedge axi_aclk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_when_full got %b want 0", s_ready);
        end
        cap_q.delete(); rise_t.delete(); exp_q.delete();
        ctrl_ch_swap = 1'b0; ctrl_mlsbf = lsbf; ctrl_samp_res = 6'(res);
        ctrl_freq_ratio = 5'($urandom_range(0, 2));
        ctrl_en = 1'b1;
        s_left = l2; s_right = r2; s_valid = 1'b1;
        got2 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axi_aclk);
            if (s_ready) begin
                @(posedge axi_aclk);
                got2 = 1'b1;
                break;
            end
        end
        #1 s_valid = 1'b0;
        checks++;
        if (!got2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_in_load got accepted=%0b busy=%b want 1 1", got2, busy);
        end
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge axi_aclk);
            if (cap_q.size() >= 2 * res + 1) begin
                reached = 1'b1;
                break;
            end
        end
        ctrl_en = 1'b0;
        wait_idle(done);
        add_frame(l1, r1, 1'b0, lsbf, res);
        add_frame(l2, r2, 1'b0, lsbf, res);
        mm = first_mismatch();
        checks++;
        if (!ok || !reached || !done || mm != -1) begin
            errors++;
            $display("FAIL back_to_back bit %0d got %b want %b (bits %0d of %0d, ok=%0b done=%0b)",
                     mm, cap_at(mm), exp_at(mm), cap_q.size(), exp_q.size(), ok, done);
        end
    endtask

    task automatic test_underflow();
        bit ok, done;
        int mm;
        ctrl_int_en = 1'b1;
        drive_frame(1'b0, '0, '0, 1'b0, 1'b0, 6'd16, 5'd1, 1'b0, ok, done);
        add_frame('0, '0, 1'b0, 1'b0, 16);
        mm = first_mismatch();
        checks++;
        if (!done || mm != -1) begin
            errors++;
            $display("FAIL underflow_zeros bit %0d got %b want %b done=%0b", mm, cap_at(mm), exp_at(mm), done);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq);
        end
        @(negedge axi_aclk); irq_clr = 1'b1;
        @(negedge axi_aclk); irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got %b want 0", irq);
        end
        ctrl_int_en = 1'b0;
        drive_frame(1'b0, '0, '0, 1'b0, 1'b0, 6'd16, 5'd1, 1'b0, ok, done);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked got %b want 0", irq);
        end
        ctrl_int_en = 1'b1;
        drive_frame(1'b0, '0, '0, 1'b0, 1'b0, 6'd16, 5'd1, 1'b0, ok, done);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_reset_again got %b want 1", irq);
        end
        drive_frame(1'b0, '0, '0, 1'b0, 1'b0, 6'd16, 5'd1, 1'b1, ok, done);
        checks++;
        if (irq !== 1'b1 || !done) begin
            errors++;
            $display("FAIL irq_set_beats_clr got %b want 1 (done=%0b)", irq, done);
        end
    endtask

    task automatic test_reset_mid_right();
        bit ok, found;
        int n;
        push_pair(32'h0000_1234, 32'h0000_FFFF, ok);
        @(negedge axi_aclk);
        cap_q.delete(); rise_t.delete();
        ctrl_ch_swap = 1'b0; ctrl_mlsbf = 1'b0; ctrl_samp_res = 6'd16; ctrl_freq_ratio = 5'd1;
        ctrl_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge axi_aclk);
            if (cap_q.size() >= 20 && i2s_sck && i2s_sd) begin
                found = 1'b1;
                break;
            end
        end
        ctrl_en = 1'b0;
        #2 axi_aresetn = 1'b0;
        #1;
        checks++;
        if (!found || {s_ready, i2s_sck, i2s_ws, i2s_sd, irq, busy} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_outputs got %b want 000000 (reached_right=%0b)",
                     {s_ready, i2s_sck, i2s_ws, i2s_sd, irq, busy}, found);
        end
        n = cap_q.size();
        repeat (3) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_mid_reset got %b want 1", s_ready);
        end
        repeat (200) @(negedge axi_aclk);
        checks++;
        if (cap_q.size() != n || busy !== 1'b0 || i2s_sck !== 1'b0) begin
            errors++;
            $display("FAIL frame_abandoned got bits=%0d busy=%b sck=%b want bits=%0d busy=0 sck=0",
                     cap_q.size(), busy, i2s_sck, n);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_back_to_back();
        test_underflow();
        test_reset_mid_right();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
